// File: rtl/midi_out.sv
// MIDI serial transmitter: one channel message per wr strobe, 8N1 idle-high line,
// with optional running-status suppression of repeated status bytes.
module midi_out #(
    parameter int CLK_HZ         = 50000000,
    parameter int BAUD           = 31250,
    parameter int RUNNING_STATUS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [3:0] ch_message,
    input  logic [3:0] chan,
    input  logic [6:0] data1,
    input  logic [6:0] data2,
    input  logic       rs_clear,
    output logic       ready,
    output logic       done,
    output logic       MIDI_OUT
);

    // state | meaning
    // IDLE  | line high, ready=1, waiting for a valid wr
    // START | start bit (line low) for one bit period
    // DATA  | 8 data bits, LSB first
    // STOP  | stop bit (line high); then next byte or DONE
    // DONE  | one-cycle done pulse
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    state_t        state, state_n;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [1:0]    ptr, last_ptr;
    logic [7:0]    status_r, rs_status;
    logic [6:0]    d1_r, d2_r;
    logic          rs_valid;
    logic          msg_valid, accept, send_status, bit_end, midi_n;
    logic [7:0]    cur_byte;

    assign msg_valid   = ch_message[3] && (ch_message != 4'hF);
    assign accept      = wr && msg_valid && (state == IDLE);
    // A same-cycle rs_clear wins over the stored status.
    assign send_status = !((RUNNING_STATUS != 0) && rs_valid && !rs_clear &&
                           (rs_status == {ch_message, chan}));
    assign bit_end     = (baud_cnt == CW'(DIV - 1));

    always_comb begin
        case (ptr)
            2'd0:    cur_byte = status_r;
            2'd1:    cur_byte = {1'b0, d1_r};
            default: cur_byte = {1'b0, d2_r};
        endcase
    end

    always_comb begin
        state_n = state;
        midi_n  = MIDI_OUT;
        ready   = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (accept) begin
                    state_n = START;
                    midi_n  = 1'b0;
                end
            end
            START: if (bit_end) begin
                state_n = DATA;
                midi_n  = cur_byte[0];
            end
            DATA: if (bit_end) begin
                if (bit_cnt == 3'd7) begin
                    state_n = STOP;
                    midi_n  = 1'b1;
                end else begin
                    midi_n = cur_byte[3'(bit_cnt + 3'd1)];
                end
            end
            STOP: if (bit_end) begin
                if (ptr != last_ptr) begin
                    state_n = START;
                    midi_n  = 1'b0;
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                midi_n  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            MIDI_OUT <= 1'b1;
        end else begin
            state    <= state_n;
            MIDI_OUT <= midi_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            ptr       <= '0;
            last_ptr  <= '0;
            status_r  <= '0;
            d1_r      <= '0;
            d2_r      <= '0;
            rs_status <= '0;
            rs_valid  <= 1'b0;
        end else begin
            if (state == START || state == DATA || state == STOP)
                baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            else
                baud_cnt <= '0;

            if (state != DATA)
                bit_cnt <= '0;
            else if (bit_end)
                bit_cnt <= bit_cnt + 3'd1;

            if (accept) begin
                status_r  <= {ch_message, chan};
                d1_r      <= data1;
                d2_r      <= data2;
                ptr       <= send_status ? 2'd0 : 2'd1;
                // Program change and channel pressure carry one data byte.
                last_ptr  <= (ch_message[3:1] == 3'b110) ? 2'd1 : 2'd2;
                rs_status <= {ch_message, chan};
                rs_valid  <= 1'b1;
            end else begin
                if (rs_clear)
                    rs_valid <= 1'b0;
                if (state == STOP && bit_end && ptr != last_ptr)
                    ptr <= ptr + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_midi_out.sv
// Directed bench for midi_out: two instances (running status on/off) at 16 clocks per bit.
module tb_midi_out;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0, wr0 = 1'b0;
    logic [3:0] ch_message = '0, chan = '0;
    logic [6:0] data1 = '0, data2 = '0;
    logic       rs_clear = 1'b0;
    logic       ready_a, done_a, line_a;
    logic       ready_b, done_b, line_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    midi_out #(.CLK_HZ(160), .BAUD(10), .RUNNING_STATUS(1)) dut (
        .clk(clk), .rst(rst), .wr(wr), .ch_message(ch_message), .chan(chan),
        .data1(data1), .data2(data2), .rs_clear(rs_clear),
        .ready(ready_a), .done(done_a), .MIDI_OUT(line_a)
    );

    midi_out #(.CLK_HZ(160), .BAUD(10), .RUNNING_STATUS(0)) dut0 (
        .clk(clk), .rst(rst), .wr(wr0), .ch_message(ch_message), .chan(chan),
        .data1(data1), .data2(data2), .rs_clear(rs_clear),
        .ready(ready_b), .done(done_b), .MIDI_OUT(line_b)
    );

    function automatic logic line_of(input bit s);
        return s ? line_b : line_a;
    endfunction
    function automatic logic ready_of(input bit s);
        return s ? ready_b : ready_a;
    endfunction
    function automatic logic done_of(input bit s);
        return s ? done_b : done_a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one message and check every byte frame, ready, and done timing.
    task automatic send_msg(input bit sel, input string tag,
                            input logic [3:0] cm, input logic [3:0] ch,
                            input logic [6:0] a, input logic [6:0] b, input int n,
                            input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                            input bit poke, input bit clr);
        logic [7:0] exp_b [3];
        logic [9:0] cap;
        int cur;
        bit rdy_ok;
        exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2;
        ch_message = cm; chan = ch; data1 = a; data2 = b; rs_clear = clr;
        if (sel) wr0 = 1'b1; else wr = 1'b1;
        step();
        wr = 1'b0; wr0 = 1'b0; rs_clear = 1'b0;
        cur = 0;
        rdy_ok = 1'b1;
        chk({tag, "_latency"}, 32'(line_of(sel)), 32'd0);
        for (int bi = 0; bi < n; bi++) begin
            cap = '0;
            for (int k = 0; k < 10; k++) begin
                while (cur < (bi * 10 + k) * DIV + DIV / 2) begin
                    step();
                    cur++;
                    if (ready_of(sel) !== 1'b0) rdy_ok = 1'b0;
                end
                cap[k] = line_of(sel);
                if (poke && bi == 0 && k == 3) begin
                    ch_message = 4'h8; chan = 4'h5; data1 = 7'h7F; data2 = 7'h55;
                    if (sel) wr0 = 1'b1; else wr = 1'b1;
                    step();
                    cur++;
                    wr = 1'b0; wr0 = 1'b0;
                end
            end
            chk($sformatf("%s_byte%0d", tag, bi), 32'(cap), 32'({1'b1, exp_b[bi], 1'b0}));
        end
        while (cur < n * 10 * DIV - 1) begin
            step();
            cur++;
            if (ready_of(sel) !== 1'b0) rdy_ok = 1'b0;
        end
        chk({tag, "_ready_busy"}, 32'(rdy_ok), 32'd1);
        chk({tag, "_done_early"}, 32'(done_of(sel)), 32'd0);
        step();
        chk({tag, "_done"}, 32'(done_of(sel)), 32'd1);
        step();
        chk({tag, "_done_end"}, 32'({done_of(sel), ready_of(sel), line_of(sel)}), 32'b011);
    endtask

    initial begin
        bit quiet;

        // Reset and idle
        #3 rst = 1'b0;
        #1 chk("reset_outputs", 32'({ready_a, done_a, line_a}), 32'b101);
        repeat (3) step();
        rst = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            step();
            if ({ready_a, done_a, line_a} !== 3'b101) quiet = 1'b0;
        end
        chk("idle_10000", 32'(quiet), 32'd1);

        // Note on, with a busy strobe poked mid-message
        send_msg(0, "note_on", 4'h9, 4'h0, 7'd60, 7'd100, 3, 8'h90, 8'h3C, 8'h64, 1, 0);
        // Running status
        send_msg(0, "rs_note", 4'h9, 4'h0, 7'd64, 7'd0, 2, 8'h40, 8'h00, 8'h00, 0, 0);
        // Running status disabled
        send_msg(1, "nors_1", 4'h9, 4'h0, 7'd60, 7'd100, 3, 8'h90, 8'h3C, 8'h64, 0, 0);
        send_msg(1, "nors_2", 4'h9, 4'h0, 7'd64, 7'd0, 3, 8'h90, 8'h40, 8'h00, 0, 0);
        // Two-byte message, then status change
        send_msg(0, "prog", 4'hC, 4'h3, 7'd5, 7'd99, 2, 8'hC3, 8'h05, 8'h00, 0, 0);
        send_msg(0, "note_off", 4'h8, 4'h3, 7'd60, 7'd0, 3, 8'h83, 8'h3C, 8'h00, 0, 0);

        // Illegal message types are ignored
        ch_message = 4'hF; chan = 4'h3; data1 = 7'd1; data2 = 7'd2; wr = 1'b1;
        step();
        ch_message = 4'h7;
        step();
        wr = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if ({ready_a, done_a, line_a} !== 3'b101) quiet = 1'b0;
            step();
        end
        chk("illegal_quiet", 32'(quiet), 32'd1);
        send_msg(0, "rs_kept", 4'h8, 4'h3, 7'd61, 7'd1, 2, 8'h3D, 8'h01, 8'h00, 0, 0);

        // rs_clear alone, then with wr in the same cycle
        rs_clear = 1'b1;
        step();
        rs_clear = 1'b0;
        send_msg(0, "rs_clr", 4'h8, 4'h3, 7'd62, 7'd2, 3, 8'h83, 8'h3E, 8'h02, 0, 0);
        send_msg(0, "rs_clr_wr", 4'h8, 4'h3, 7'd63, 7'd3, 3, 8'h83, 8'h3F, 8'h03, 0, 1);
        // Accepted the cycle ready returns (zero-gap chain)
        send_msg(0, "b2b", 4'h8, 4'h3, 7'd64, 7'd4, 2, 8'h40, 8'h04, 8'h00, 0, 0);
        send_msg(0, "chpress", 4'hD, 4'h3, 7'd9, 7'd77, 2, 8'hD3, 8'h09, 8'h00, 0, 0);
        send_msg(0, "chp_rs", 4'hD, 4'h3, 7'd10, 7'd77, 1, 8'h0A, 8'h00, 8'h00, 0, 0);

        // Reset during a data bit (bit0 of 0x90 is low)
        ch_message = 4'h9; chan = 4'h0; data1 = 7'd60; data2 = 7'd100; wr = 1'b1;
        step();
        wr = 1'b0;
        repeat (DIV + DIV / 2) step();
        chk("mid_bit_low", 32'(line_a), 32'd0);
        #2 rst = 1'b0;
        #1 chk("async_reset", 32'({ready_a, done_a, line_a}), 32'b101);
        step();
        #2 rst = 1'b1;
        step();
        chk("post_reset_idle", 32'({ready_a, done_a, line_a}), 32'b101);
        send_msg(0, "post_reset", 4'h9, 4'h0, 7'd1, 7'd2, 3, 8'h90, 8'h01, 8'h02, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/midi_out.md
Name: midi_out

Overview:
- Serial MIDI transmitter: takes one decoded channel message per strobe and sends it as a standard MIDI byte stream on a 31250-baud, 8N1, idle-high line.
- Counterpart of the midi_in receiver. Its message inputs use the same field encoding midi_in produces: CH_MESSAGE, CHAN, LSB/NOTE, MSB/VELOCITY.
- Sits in the synth top to echo or forward messages (MIDI THRU / sequencer out). Supports optional running status.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 31250, line bit rate.
- RUNNING_STATUS, 1, 1 = omit the status byte when it equals the last transmitted status; 0 = always send it.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr  in  1  one-cycle message strobe; honoured only when ready=1.
- ch_message  in  4  message type, the status high nibble (8,9,A,B,C,D,E valid).
- chan  in  4  MIDI channel 0..15.
- data1  in  7  first data byte (note / controller / program / pitch LSB).
- data2  in  7  second data byte (velocity / value / pitch MSB).
- rs_clear  in  1  one-cycle pulse; forgets the running status.
- ready  out  1  1 = idle; a wr this cycle is accepted.
- done  out  1  one-cycle pulse after the stop bit of a message's last byte.
- MIDI_OUT  out  1  serial line; idle high.

Behaviour:
- Reset (rst=0, asynchronous):
  - MIDI_OUT=1, ready=1, done=0.
  - FSM goes to IDLE; bit and baud counters clear.
  - Running-status register becomes invalid.
  - Reset mid-frame aborts immediately; the line returns high with no partial stop bit.
- Bit period: DIV = CLK_HZ/BAUD, integer division (1600 cycles at the defaults). The baud counter runs 0..DIV-1 and restarts at every byte start.
- Accept rule:
  - In IDLE, wr=1 with a valid ch_message latches status = {ch_message, chan}, data1 and data2. ready drops to 0 on the next cycle.
  - wr while ready=0 is ignored; no queue.
  - wr with ch_message < 8 or = F is ignored: ready stays 1, no output, running status unchanged.
- Byte count:
  - 8, 9, A, B, E: status + 2 data bytes.
  - C, D: status + 1 data byte (data1 only; data2 ignored).
- Running status:
  - If RUNNING_STATUS=1, the stored status is valid and equals the new status, the status byte is skipped.
  - Otherwise the status is sent and stored as valid.
  - rs_clear invalidates it. If rs_clear and wr occur in the same cycle, the clear takes effect first, so the status byte is sent.
  - Data bytes go out with bit7=0.
- FSM: IDLE -> START -> DATA -> STOP -> (NEXT byte ? START : DONE) -> IDLE.
  - START: MIDI_OUT=0 for DIV cycles.
  - DATA: 8 bits LSB first, DIV cycles each.
  - STOP: MIDI_OUT=1 for DIV cycles.
  - DONE: asserts done for exactly one cycle, then IDLE with ready=1.
- Back-to-back bytes within a message: the next start bit begins the cycle after the previous stop bit ends; no inter-byte gap.
- Latency: MIDI_OUT falls in the first cycle after the accepting edge.
- Message duration:
  - 3 bytes: 30*DIV cycles.
  - 2 bytes: 20*DIV.
  - 1 data byte under running status: 10*DIV.
- A new wr in the same cycle ready returns to 1 is accepted; the stream then has zero idle gap.
- MIDI_OUT is driven from a register (glitch-free).

Test Plan:
- Reset: hold rst=0, then release, no wr -> MIDI_OUT=1, ready=1, done=0 for 10000 cycles.
- Note on: wr with ch_message=9, chan=0, data1=60, data2=100 -> bytes 0x90, 0x3C, 0x64 on the line. Each byte is start 0, 8 bits LSB first, stop 1, at 1600 cycles/bit. done pulses at cycle 48000 after accept. ready=0 for the whole message.
- Running status: repeat the note on with data1=64, data2=0 -> only 0x40, 0x00 sent (32000 cycles). With RUNNING_STATUS=0 -> 0x90 is resent.
- Two-byte message and status change: program change ch_message=C, chan=3, data1=5 -> 0xC3, 0x05. A following note off 8/3/60/0 -> 0x83, 0x3C, 0x00, status sent.
- Illegal and busy strobes:
  - wr with ch_message=F -> no line activity; ready stays 1.
  - wr mid-message -> ignored; the in-flight bytes are unchanged.
- rs_clear and reset:
  - rs_clear pulse, then a repeat of the same status -> status byte is sent.
  - rst low during a data bit -> MIDI_OUT=1 asynchronously.
  - The next message after reset always includes its status byte.
